// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-frame player x/row stepping, jump arc, death/respawn hold, level completion (in: clk rst frame_tick jump restart collide; out: player_x player_y sub_lv dir_right jumping jump_ost lv_done dead death_cnt)
module player_motion_ctrl #(
  parameter int pA             = 12,
  parameter int SCREEN_W       = 640,
  parameter int PLAYER_W       = 20,
  parameter int STEP           = 1,
  parameter int JUMP_LEN       = 70,
  parameter int RESPAWN_FRAMES = 30,
  parameter int ROW0_Y         = 139,
  parameter int ROW1_Y         = 300,
  parameter int ROW2_Y         = 459,
  parameter int DONE_Y         = 480
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_tick,
  input  logic          jump,
  input  logic          restart,
  input  logic          collide,
  output logic [pA-1:0] player_x,
  output logic [pA-1:0] player_y,
  output logic [1:0]    sub_lv,
  output logic          dir_right,
  output logic          jumping,
  output logic [6:0]    jump_ost,
  output logic          lv_done,
  output logic          dead,
  output logic [7:0]    death_cnt
);
  localparam logic [pA-1:0] X_MAX = pA'(SCREEN_W - PLAYER_W);
  localparam logic [pA-1:0] STP   = pA'(STEP);
  localparam logic [6:0]    LAST  = 7'(JUMP_LEN - 1);
  localparam logic [6:0]    HALF  = 7'(JUMP_LEN / 2);
  localparam int            HW    = $clog2(RESPAWN_FRAMES + 1);
  typedef enum logic [1:0] {PLAY, DEAD, DONE} state_t;
  state_t          state, state_n;
  logic [pA-1:0]   x_n, base;
  logic [1:0]      lv_n;
  logic            jmp_n, at_end;
  logic [6:0]      phase, phase_n;
  logic [7:0]      cnt_n;
  logic [HW-1:0]   hold, hold_n;
  assign dir_right = sub_lv != 2'd1;
  assign at_end    = dir_right ? player_x == X_MAX : player_x == '0;
  assign lv_done   = state == DONE;
  assign dead      = state == DEAD;
  assign jump_ost  = lv_done ? 7'd0 : phase <= HALF ? phase : 7'(JUMP_LEN) - phase;
  assign base      = sub_lv == 2'd0 ? pA'(ROW0_Y) : sub_lv == 2'd1 ? pA'(ROW1_Y) :
                     sub_lv == 2'd2 ? pA'(ROW2_Y) : pA'(DONE_Y);
  assign player_y  = base - pA'(jump_ost);
  always_comb begin
    state_n = state;
    x_n     = player_x;
    lv_n    = sub_lv;
    jmp_n   = jumping;
    phase_n = phase;
    cnt_n   = death_cnt;
    hold_n  = hold;
    if (state == PLAY && collide) begin
      state_n = DEAD;
      x_n     = dir_right ? '0 : X_MAX;
      jmp_n   = 1'b0;
      phase_n = '0;
      cnt_n   = death_cnt + 8'(death_cnt != 8'hff);
      hold_n  = '0;
    end else if (state == PLAY) begin
      if (frame_tick) begin
        x_n  = at_end ? player_x :
               dir_right ? (player_x >= X_MAX - STP ? X_MAX : player_x + STP) :
                           (player_x <= STP ? '0 : player_x - STP);
        lv_n = at_end ? sub_lv + 2'd1 : sub_lv;
        if (jumping) begin
          phase_n = phase == LAST ? '0 : phase + 7'd1;
          jmp_n   = phase != LAST;
        end
      end
      if (jump && !jumping) begin
        jmp_n   = 1'b1;
        phase_n = '0;
      end
      if (frame_tick && at_end && sub_lv == 2'd2) begin
        state_n = DONE;
        jmp_n   = 1'b0;
        phase_n = '0;
      end
    end else if (state == DEAD && frame_tick) begin
      state_n = hold == HW'(RESPAWN_FRAMES - 1) ? PLAY : DEAD;
      hold_n  = hold + HW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst || restart) begin
      state    <= PLAY;
      player_x <= '0;
      sub_lv   <= '0;
      jumping  <= 1'b0;
      phase    <= '0;
      hold     <= '0;
    end else begin
      state    <= state_n;
      player_x <= x_n;
      sub_lv   <= lv_n;
      jumping  <= jmp_n;
      phase    <= phase_n;
      hold     <= hold_n;
    end
    death_cnt <= !rst ? '0 : restart ? death_cnt : cnt_n;
  end
endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl: directed and randomized checks of player_motion_ctrl against a frame-level model
module tb_player_motion_ctrl;
  logic        clk = 0, rst = 0, frame_tick = 0, jump = 0, restart = 0, collide = 0;
  logic [11:0] player_x, player_y;
  logic [1:0]  sub_lv;
  logic        dir_right, jumping, lv_done, dead;
  logic [6:0]  jump_ost;
  logic [7:0]  death_cnt;
  int errors = 0, checks = 0;
  int m_x, m_lv, m_mode, m_jf, m_deaths, m_hold;
  int row_y[4] = '{139, 300, 459, 480};
  player_motion_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .jump(jump), .restart(restart), .collide(collide),
    .player_x(player_x), .player_y(player_y), .sub_lv(sub_lv), .dir_right(dir_right), .jumping(jumping),
    .jump_ost(jump_ost), .lv_done(lv_done), .dead(dead), .death_cnt(death_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [44:0] model_vec();
    int ost, y;
    ost = (m_mode == 2 || m_jf < 0) ? 0 : (m_jf <= 35 ? m_jf : 70 - m_jf);
    y   = row_y[m_mode == 2 ? 3 : m_lv] - ost;
    return {12'(m_x), 12'(y), 2'(m_lv), 1'(m_lv != 1), 1'(m_jf >= 0), 7'(ost),
            1'(m_mode == 2), 1'(m_mode == 1), 8'(m_deaths)};
  endfunction
  task automatic cyc(input logic ft, input logic jp, input logic co, input logic rs, input logic r_n);
    bit arm;
    frame_tick = ft; jump = jp; collide = co; restart = rs; rst = r_n;
    @(posedge clk);
    if (!r_n || rs) begin
      m_x = 0; m_lv = 0; m_mode = 0; m_jf = -1; m_hold = 0;
      if (!r_n) m_deaths = 0;
    end else if (m_mode == 0) begin
      if (co) begin
        m_mode = 1; m_x = (m_lv == 1) ? 620 : 0; m_jf = -1; m_hold = 0;
        if (m_deaths < 255) m_deaths++;
      end else begin
        arm = jp && m_jf < 0;
        if (ft) begin
          if (m_lv == 1) begin
            if (m_x == 0) m_lv = 2; else m_x = (m_x - 1 < 0) ? 0 : m_x - 1;
          end else if (m_x == 620) begin
            m_lv++;
            if (m_lv == 3) m_mode = 2;
          end else m_x = (m_x + 1 > 620) ? 620 : m_x + 1;
          if (m_jf >= 0) m_jf = (m_jf == 69) ? -1 : m_jf + 1;
        end
        if (arm) m_jf = 0;
        if (m_mode == 2) m_jf = -1;
      end
    end else if (m_mode == 1 && ft) begin
      m_hold++;
      if (m_hold == 30) m_mode = 0;
    end
    #1;
    frame_tick = 0; jump = 0; collide = 0; restart = 0; rst = 1;
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      cyc(1, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
    end
  endtask
  task automatic test_reset();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    checks++; if (player_x !== 12'd0) begin errors++; $display("FAIL reset_x: got %0d want 0", player_x); end
    checks++; if (player_y !== 12'd139) begin errors++; $display("FAIL reset_y: got %0d want 139", player_y); end
    checks++; if (sub_lv !== 2'd0 || dir_right !== 1'b1) begin errors++; $display("FAIL reset_lv: got lv=%0d dir=%0b want 0/1", sub_lv, dir_right); end
    checks++; if ({jumping, jump_ost, lv_done, dead, death_cnt} !== 18'd0) begin errors++; $display("FAIL reset_flags: got j=%0b o=%0d d=%0b dd=%0b c=%0d want zeros", jumping, jump_ost, lv_done, dead, death_cnt); end
  endtask
  task automatic test_traverse();
    cyc(0, 0, 0, 0, 0);
    tick(620);
    checks++; if (player_x !== 12'd620 || sub_lv !== 2'd0) begin errors++; $display("FAIL trav_620: got x=%0d lv=%0d want 620/0", player_x, sub_lv); end
    tick(1);
    checks++; if (sub_lv !== 2'd1 || dir_right !== 1'b0 || player_x !== 12'd620) begin errors++; $display("FAIL trav_row1: got lv=%0d dir=%0b x=%0d want 1/0/620", sub_lv, dir_right, player_x); end
    checks++; if (player_y !== 12'd300) begin errors++; $display("FAIL trav_row1_y: got %0d want 300", player_y); end
    tick(620);
    checks++; if (player_x !== 12'd0 || sub_lv !== 2'd1) begin errors++; $display("FAIL trav_left: got x=%0d lv=%0d want 0/1", player_x, sub_lv); end
    tick(1);
    checks++; if (sub_lv !== 2'd2 || player_x !== 12'd0 || player_y !== 12'd459) begin errors++; $display("FAIL trav_row2: got lv=%0d x=%0d y=%0d want 2/0/459", sub_lv, player_x, player_y); end
  endtask
  task automatic test_jump();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    checks++; if (jumping !== 1'b1 || jump_ost !== 7'd0) begin errors++; $display("FAIL jump_arm: got j=%0b o=%0d want 1/0", jumping, jump_ost); end
    tick(10);
    cyc(0, 1, 0, 0, 1);
    tick(25);
    checks++; if (jump_ost !== 7'd35 || player_y !== 12'd104) begin errors++; $display("FAIL jump_peak: got o=%0d y=%0d want 35/104", jump_ost, player_y); end
    tick(34);
    checks++; if (jump_ost !== 7'd1 || jumping !== 1'b1) begin errors++; $display("FAIL jump_69: got o=%0d j=%0b want 1/1", jump_ost, jumping); end
    tick(1);
    checks++; if (jumping !== 1'b0 || jump_ost !== 7'd0 || player_y !== 12'd139) begin errors++; $display("FAIL jump_land: got j=%0b o=%0d y=%0d want 0/0/139", jumping, jump_ost, player_y); end
    checks++; if ({player_x, player_y, sub_lv, dir_right, jumping, jump_ost, lv_done, dead, death_cnt} !== model_vec()) begin errors++; $display("FAIL jump_model: got %h want %h", {player_x, player_y, sub_lv, dir_right, jumping, jump_ost, lv_done, dead, death_cnt}, model_vec()); end
  endtask
  task automatic test_collide_row1();
    cyc(0, 0, 0, 0, 0);
    tick(621 + 220);
    checks++; if (player_x !== 12'd400 || sub_lv !== 2'd1) begin errors++; $display("FAIL c1_pos: got x=%0d lv=%0d want 400/1", player_x, sub_lv); end
    cyc(0, 1, 1, 0, 1);
    checks++; if (dead !== 1'b1 || player_x !== 12'd620 || death_cnt !== 8'd1 || jumping !== 1'b0) begin errors++; $display("FAIL c1_hit: got dead=%0b x=%0d c=%0d j=%0b want 1/620/1/0", dead, player_x, death_cnt, jumping); end
    tick(29);
    cyc(0, 1, 1, 0, 1);
    checks++; if (dead !== 1'b1 || player_x !== 12'd620 || death_cnt !== 8'd1 || jumping !== 1'b0) begin errors++; $display("FAIL c1_frozen: got dead=%0b x=%0d c=%0d j=%0b want 1/620/1/0", dead, player_x, death_cnt, jumping); end
    tick(1);
    checks++; if (dead !== 1'b0 || player_x !== 12'd620) begin errors++; $display("FAIL c1_respawn: got dead=%0b x=%0d want 0/620", dead, player_x); end
    tick(1);
    checks++; if (player_x !== 12'd619 || dir_right !== 1'b0) begin errors++; $display("FAIL c1_resume: got x=%0d dir=%0b want 619/0", player_x, dir_right); end
  endtask
  task automatic test_collide_wall();
    cyc(0, 0, 0, 0, 0);
    tick(620);
    cyc(1, 0, 1, 0, 1);
    checks++; if (sub_lv !== 2'd0 || player_x !== 12'd0 || death_cnt !== 8'd1 || dead !== 1'b1) begin errors++; $display("FAIL wall_death: got lv=%0d x=%0d c=%0d dead=%0b want 0/0/1/1", sub_lv, player_x, death_cnt, dead); end
  endtask
  task automatic test_done();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1);
    tick(30);
    tick(1863);
    checks++; if (lv_done !== 1'b1 || player_y !== 12'd480 || sub_lv !== 2'd3 || jump_ost !== 7'd0) begin errors++; $display("FAIL done: got ld=%0b y=%0d lv=%0d o=%0d want 1/480/3/0", lv_done, player_y, sub_lv, jump_ost); end
    repeat (4) cyc(1, 1, 1, 0, 1);
    checks++; if (lv_done !== 1'b1 || dead !== 1'b0 || jumping !== 1'b0 || death_cnt !== 8'd1 || player_x !== 12'd620) begin errors++; $display("FAIL done_ignore: got ld=%0b dead=%0b j=%0b c=%0d x=%0d want 1/0/0/1/620", lv_done, dead, jumping, death_cnt, player_x); end
    cyc(0, 0, 0, 1, 1);
    checks++; if (sub_lv !== 2'd0 || player_x !== 12'd0 || death_cnt !== 8'd1 || lv_done !== 1'b0 || player_y !== 12'd139) begin errors++; $display("FAIL restart: got lv=%0d x=%0d c=%0d ld=%0b y=%0d want 0/0/1/0/139", sub_lv, player_x, death_cnt, lv_done, player_y); end
  endtask
  task automatic test_saturate_and_reset();
    cyc(0, 0, 0, 0, 0);
    repeat (255) begin
      cyc(0, 0, 1, 0, 1);
      tick(30);
    end
    checks++; if (death_cnt !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d want 255", death_cnt); end
    cyc(0, 0, 1, 0, 1);
    checks++; if (death_cnt !== 8'd255 || dead !== 1'b1) begin errors++; $display("FAIL sat_hold: got c=%0d dead=%0b want 255/1", death_cnt, dead); end
    tick(5);
    cyc(0, 0, 0, 0, 0);
    checks++; if ({player_x, player_y, sub_lv, dir_right, jumping, jump_ost, lv_done, dead, death_cnt} !== {12'd0, 12'd139, 2'd0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 8'd0}) begin errors++; $display("FAIL rst_dead: got %h", {player_x, player_y, sub_lv, dir_right, jumping, jump_ost, lv_done, dead, death_cnt}); end
    cyc(0, 1, 0, 0, 1);
    tick(20);
    cyc(0, 0, 0, 0, 0);
    checks++; if ({player_x, player_y, sub_lv, dir_right, jumping, jump_ost, lv_done, dead, death_cnt} !== {12'd0, 12'd139, 2'd0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 8'd0}) begin errors++; $display("FAIL rst_jump: got %h", {player_x, player_y, sub_lv, dir_right, jumping, jump_ost, lv_done, dead, death_cnt}); end
  endtask
  task automatic test_random();
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 5000; i++) begin
      cyc($urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 399) == 0,
          $urandom_range(0, 1999) == 0, $urandom_range(0, 2999) != 0);
      checks++;
      if ({player_x, player_y, sub_lv, dir_right, jumping, jump_ost, lv_done, dead, death_cnt} !== model_vec()) begin
        errors++;
        $display("FAIL random_%0d: got %h want %h", i, {player_x, player_y, sub_lv, dir_right, jumping, jump_ost, lv_done, dead, death_cnt}, model_vec());
      end
    end
  endtask
  initial begin
    m_x = 0; m_lv = 0; m_mode = 0; m_jf = -1; m_deaths = 0; m_hold = 0;
    test_reset();
    test_traverse();
    test_jump();
    test_collide_row1();
    test_collide_wall();
    test_done();
    test_saturate_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
